// File: rtl/ftoi_arbiter_pkg.sv
// Shared types for the ftoi arbiter: tag pipe entries, result FIFO entries, pipeline depths.
package ftoi_arbiter_pkg;

   localparam int FTOI_LAT = 2;
   localparam int ARB_LAT  = FTOI_LAT + 1;
   localparam int ID_W     = 3;   // wide enough for NREQ up to 8; the top truncates to IDW

   typedef struct packed {
      logic            v;
      logic [ID_W-1:0] id;
   } tag_t;

   typedef struct packed {
      logic [31:0]     data;
      logic [ID_W-1:0] id;
   } res_entry_t;

   function automatic int unsigned inflight_cnt(input tag_t [ARB_LAT-1:0] tags);
      inflight_cnt = 0;
      for (int i = 0; i < ARB_LAT; i++) begin
         if (tags[i].v) inflight_cnt++;
      end
   endfunction

endpackage

// File: rtl/ftoi_arbiter_if.sv
// Requester-side and result-side handshake bundle of the ftoi arbiter.
interface ftoi_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*32-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               res_valid;
   logic               res_ready;
   logic [31:0]        res_data;
   logic [IDW-1:0]     res_id;
   logic               busy;

   modport master (
      output req_valid, req_data, res_ready,
      input  req_ready, res_valid, res_data, res_id, busy
   );

   modport slave (
      input  req_valid, req_data, res_ready,
      output req_ready, res_valid, res_data, res_id, busy
   );
endinterface

// File: rtl/ftoi.sv
// Two-stage float32 -> int32 converter: stage 1 aligns 2*|x|, stage 2 rounds half away and applies sign.
module ftoi (
   input  logic        clk,
   input  logic [31:0] x,
   output logic [31:0] y
);
   logic [7:0]  exp_w;
   logic [32:0] v2_w;
   logic [32:0] mag_w;
   logic [32:0] y1_v2_q;
   logic        y1_neg_q;
   logic        y1_zero_q;

   assign exp_w = x[30:23];
   // v2 = floor(2*|x|); its LSB is the half bit used for rounding
   assign v2_w  = 33'(({32'b0, 1'b1, x[22:0]} << (exp_w - 8'd126)) >> 23);
   assign mag_w = (y1_v2_q + 33'd1) >> 1;

   always_ff @(posedge clk) begin
      y1_v2_q   <= v2_w;
      y1_neg_q  <= x[31];
      y1_zero_q <= (exp_w < 8'd126) || (exp_w > 8'd158);
   end

   always_ff @(posedge clk) begin
      if (y1_zero_q)     y <= 32'h0;
      else if (y1_neg_q) y <= -mag_w[31:0];
      else               y <= mag_w[31:0];
   end
endmodule

// File: rtl/ftoi_arbiter_res_fifo.sv
// In-order synchronous result FIFO with occupancy count; pop on empty is ignored.
module ftoi_arbiter_res_fifo
   import ftoi_arbiter_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push_i,
   input  res_entry_t    push_dat_i,
   input  logic          pop_i,
   output res_entry_t    head_o,
   output logic          vld_o,
   output logic [CW-1:0] count_o
);
   res_entry_t    mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign do_pop  = pop_i && (cnt_q != '0);
   assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_dat_i;
   end

   assign head_o  = mem_q[rd_q];
   assign vld_o   = (cnt_q != '0);
   assign count_o = cnt_q;
endmodule

// File: rtl/ftoi_arbiter.sv
// Round-robin shares one 2-stage ftoi among NREQ requesters; tags ride alongside and results
// drain through a FIFO. Issue is credit-gated so the FIFO can never overflow.
module ftoi_arbiter
   import ftoi_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ),
   parameter int DEPTH = 8
) (
   input logic           clk,
   input logic           rstn,
   ftoi_arbiter_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [IDW-1:0]     ptr_q, ptr_d, gnt_id;
   logic               gnt_found, can_issue, accept;
   tag_t [ARB_LAT-1:0] tag_q, tag_d;
   tag_t               tag_in;
   logic [31:0]        x_q, y;
   logic [CW-1:0]      fifo_cnt;
   logic               fifo_vld;
   res_entry_t         push_dat, head;

   always_comb begin : rr_scan
      logic [IDW-1:0] idx;
      gnt_found = 1'b0;
      gnt_id    = '0;
      idx       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (!gnt_found && bus.req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = idx;
         end
      end
   end

   // A pop in the same cycle is not credited back until the count actually drops
   assign can_issue = (int'(fifo_cnt) + int'(inflight_cnt(tag_q))) < DEPTH;
   assign accept    = gnt_found && can_issue;
   assign bus.req_ready = (accept && rstn) ? (NREQ'(1) << gnt_id) : '0;

   always_comb begin
      ptr_d     = accept ? gnt_id : ptr_q;
      tag_in.v  = accept;
      tag_in.id = ID_W'(gnt_id);
      tag_d     = {tag_q[ARB_LAT-2:0], tag_in};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q <= IDW'(NREQ - 1);
         tag_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         tag_q <= tag_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) x_q <= bus.req_data[{gnt_id, 5'b0} +: 32];
   end

   ftoi u_ftoi (
      .clk (clk),
      .x   (x_q),
      .y   (y)
   );

   always_comb begin
      push_dat.data = y;
      push_dat.id   = tag_q[ARB_LAT-1].id;
   end

   ftoi_arbiter_res_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .push_i     (tag_q[ARB_LAT-1].v),
      .push_dat_i (push_dat),
      .pop_i      (bus.res_ready),
      .head_o     (head),
      .vld_o      (fifo_vld),
      .count_o    (fifo_cnt)
   );

   assign bus.res_valid = fifo_vld;
   assign bus.res_data  = head.data;
   assign bus.res_id    = IDW'(head.id);
   assign bus.busy      = (inflight_cnt(tag_q) != 0) || (fifo_cnt != '0);
endmodule
